// File: rtl/segway_pkg.sv
// Shared types and constants for the segway motor-drive path.
// Speed-to-duty mapping lives here so every consumer clamps identically.
package segway_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    SHTDWN = 1'b1
  } ovr_state_t;

  localparam int                PWM_W    = 11;
  localparam logic [PWM_W-1:0]  DUTY_MID = 11'h400;
  localparam logic signed [11:0] SPD_MAX = 12'sd1023;
  localparam logic signed [11:0] SPD_MIN = -12'sd1024;

  // Clamp to the 11-bit signed range, then bias so zero speed lands on mid-scale.
  function automatic logic [PWM_W-1:0] spd_to_duty(input logic signed [11:0] spd);
    logic signed [11:0] clamped;
    if (spd > SPD_MAX)
      clamped = SPD_MAX;
    else if (spd < SPD_MIN)
      clamped = SPD_MIN;
    else
      clamped = spd;
    return PWM_W'(clamped + 12'sd1024);
  endfunction

endpackage

// File: rtl/mtr_pwm_drv_nonoverlap.sv
// Complementary gate pair with dead-time on every edge of the raw PWM signal.
// force_off parks both gates low; the edge detector keeps tracking meanwhile.
module nonoverlap #(
  parameter int NONOVERLAP = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  input  logic force_off,
  output logic pwm1,
  output logic pwm2
);

  localparam int DW = $clog2(NONOVERLAP + 1);

  logic          sig_q;
  logic          sig_edge;
  logic [DW-1:0] dead_cnt;

  assign sig_edge = sig ^ sig_q;

  // The edge cycle itself is the first dead cycle, so the down-counter loads one less.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q    <= 1'b0;
      dead_cnt <= '0;
      pwm1     <= 1'b0;
      pwm2     <= 1'b0;
    end else begin
      sig_q <= sig;
      if (force_off) begin
        dead_cnt <= '0;
        pwm1     <= 1'b0;
        pwm2     <= 1'b0;
      end else if (sig_edge) begin
        dead_cnt <= DW'(NONOVERLAP - 1);
        pwm1     <= 1'b0;
        pwm2     <= 1'b0;
      end else if (dead_cnt != '0) begin
        dead_cnt <= dead_cnt - DW'(1);
        pwm1     <= 1'b0;
        pwm2     <= 1'b0;
      end else begin
        pwm1 <= sig;
        pwm2 <= ~sig;
      end
    end
  end

endmodule

// File: rtl/mtr_pwm_drv.sv
// H-bridge PWM driver for both motors with optional over-current shutdown.
// Shutdown FSM is built only when MTR_OVR_I_SHTDWN_EN is defined.
//
//   state  | meaning
//   RUN    | gates follow PWM, faulted periods counted
//   SHTDWN | all gates off, held until pwr_up drops
module mtr_pwm_drv
  import segway_pkg::*;
#(
  parameter int NONOVERLAP  = 32,
  parameter int OVR_I_BLANK = 128,
  parameter int OVR_LIMIT   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pwr_up,
  input  logic [11:0] lft_spd,
  input  logic [11:0] rght_spd,
  input  logic        OVR_I,
  output logic        lft_pwm1,
  output logic        lft_pwm2,
  output logic        rght_pwm1,
  output logic        rght_pwm2,
  output logic        PWM_synch,
  output logic        shtdwn
);

  logic [PWM_W-1:0] cnt;
  logic [PWM_W-1:0] lft_duty;
  logic [PWM_W-1:0] rght_duty;
  logic             lft_sig;
  logic             rght_sig;
  logic             gate_en;
  logic             shut;
  logic             force_off;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else
      cnt <= cnt + PWM_W'(1);
  end

  assign PWM_synch = (cnt == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_duty  <= DUTY_MID;
      rght_duty <= DUTY_MID;
    end else if (PWM_synch) begin
      lft_duty  <= spd_to_duty(lft_spd);
      rght_duty <= spd_to_duty(rght_spd);
    end
  end

  assign lft_sig  = (cnt < lft_duty);
  assign rght_sig = (cnt < rght_duty);

  // Re-enable only at a wrap so a pwr_up rise never produces a partial first period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      gate_en <= 1'b1;
    else if (!pwr_up)
      gate_en <= 1'b0;
    else if (PWM_synch)
      gate_en <= 1'b1;
  end

  assign force_off = ~(gate_en & pwr_up) | shut;

`ifdef MTR_OVR_I_SHTDWN_EN
  localparam int FW = $clog2(OVR_LIMIT + 1);

  ovr_state_t    state;
  ovr_state_t    nxt_state;
  logic [FW-1:0] flt_cnt;
  logic          flt_seen;
  logic          flt_now;
  logic          period_flt;
  logic          trip;

  assign flt_now    = OVR_I & (cnt >= PWM_W'(OVR_I_BLANK)) & (lft_pwm1 | rght_pwm1);
  assign period_flt = flt_seen | flt_now;
  assign trip       = PWM_synch & period_flt & (flt_cnt == FW'(OVR_LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= RUN;
    else
      state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    case (state)
      RUN:     if (pwr_up && trip) nxt_state = SHTDWN;
      SHTDWN:  if (!pwr_up) nxt_state = RUN;
      default: nxt_state = RUN;
    endcase
  end

  always_comb begin
    shut = 1'b0;
    if (state == SHTDWN)
      shut = 1'b1;
  end

  // A fault on the wrap cycle still belongs to the period that is ending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flt_cnt  <= '0;
      flt_seen <= 1'b0;
    end else if (!pwr_up) begin
      flt_cnt  <= '0;
      flt_seen <= 1'b0;
    end else if (state == RUN) begin
      if (PWM_synch) begin
        flt_cnt  <= period_flt ? flt_cnt + FW'(1) : '0;
        flt_seen <= 1'b0;
      end else begin
        flt_seen <= period_flt;
      end
    end
  end

  assign shtdwn = shut;
`else
  logic unused_ovr_i;
  localparam int unused_ovr_params = OVR_I_BLANK + OVR_LIMIT;

  assign unused_ovr_i = OVR_I;
  assign shut         = 1'b0;
  assign shtdwn       = 1'b0;
`endif

  nonoverlap #(.NONOVERLAP(NONOVERLAP)) u_lft_no (
    .clk       (clk),
    .rst_n     (rst_n),
    .sig       (lft_sig),
    .force_off (force_off),
    .pwm1      (lft_pwm1),
    .pwm2      (lft_pwm2)
  );

  nonoverlap #(.NONOVERLAP(NONOVERLAP)) u_rght_no (
    .clk       (clk),
    .rst_n     (rst_n),
    .sig       (rght_sig),
    .force_off (force_off),
    .pwm1      (rght_pwm1),
    .pwm2      (rght_pwm2)
  );

endmodule

// File: tb/tb_mtr_pwm_drv.sv
// Directed bench for mtr_pwm_drv; samples on the falling edge, one period per run.
module tb_mtr_pwm_drv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pwr_up;
  logic [11:0] lft_spd;
  logic [11:0] rght_spd;
  logic        OVR_I;
  logic        lft_pwm1, lft_pwm2, rght_pwm1, rght_pwm2;
  logic        PWM_synch;
  logic        shtdwn;

  int n_chk  = 0;
  int n_pass = 0;

  int   p1l_hi, p2l_hi, p1r_hi, p2r_hi;
  int   overlap, late_gates, synch_hi, synch_idx;
  logic sh_first, sh_any;

  mtr_pwm_drv dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pwr_up    (pwr_up),
    .lft_spd   (lft_spd),
    .rght_spd  (rght_spd),
    .OVR_I     (OVR_I),
    .lft_pwm1  (lft_pwm1),
    .lft_pwm2  (lft_pwm2),
    .rght_pwm1 (rght_pwm1),
    .rght_pwm2 (rght_pwm2),
    .PWM_synch (PWM_synch),
    .shtdwn    (shtdwn)
  );

  always #10 clk = ~clk;

  task automatic wait_synch();
    for (int i = 0; i < 4096; i++) begin
      @(negedge clk);
      if (PWM_synch === 1'b1) return;
    end
    n_chk++;
    $display("FAIL wait_synch: no PWM_synch within 4096 cycles, required within 2048");
  endtask

  // Samples cnt 0..2047 of one period; must be entered at the cnt==2047 negedge.
  task automatic run_period(input int ovr_from, input int ovr_to);
    p1l_hi = 0; p2l_hi = 0; p1r_hi = 0; p2r_hi = 0;
    overlap = 0; late_gates = 0; synch_hi = 0; synch_idx = -1;
    sh_first = 1'b0; sh_any = 1'b0;
    for (int idx = 0; idx < 2048; idx++) begin
      @(negedge clk);
      if (lft_pwm1)  p1l_hi++;
      if (lft_pwm2)  p2l_hi++;
      if (rght_pwm1) p1r_hi++;
      if (rght_pwm2) p2r_hi++;
      if ((lft_pwm1 && lft_pwm2) || (rght_pwm1 && rght_pwm2)) overlap++;
      if (idx >= 1 && (lft_pwm1 || lft_pwm2 || rght_pwm1 || rght_pwm2)) late_gates++;
      if (PWM_synch) begin synch_hi++; synch_idx = idx; end
      if (idx == 0) sh_first = shtdwn;
      sh_any = sh_any | shtdwn;
      OVR_I = (idx >= ovr_from && idx < ovr_to);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pwr_up = 1'b1; OVR_I = 1'b0;
    lft_spd = 12'h000; rght_spd = 12'h000;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({lft_pwm1, lft_pwm2, rght_pwm1, rght_pwm2, PWM_synch, shtdwn} !== 6'b0)
      $display("FAIL reset_outputs: got %b expected 000000",
               {lft_pwm1, lft_pwm2, rght_pwm1, rght_pwm2, PWM_synch, shtdwn});
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_stopped_50pct();
    wait_synch();
    run_period(2048, 2048);
    n_chk++;
    if (p1l_hi !== 992) $display("FAIL t1_lft_pwm1: got %0d expected 992", p1l_hi); else n_pass++;
    n_chk++;
    if (p2l_hi !== 992) $display("FAIL t1_lft_pwm2: got %0d expected 992", p2l_hi); else n_pass++;
    n_chk++;
    if (p1r_hi !== 992) $display("FAIL t1_rght_pwm1: got %0d expected 992", p1r_hi); else n_pass++;
    n_chk++;
    if (p2r_hi !== 992) $display("FAIL t1_rght_pwm2: got %0d expected 992", p2r_hi); else n_pass++;
    n_chk++;
    if (overlap !== 0) $display("FAIL t1_overlap: got %0d expected 0", overlap); else n_pass++;
    n_chk++;
    if (synch_hi !== 1 || synch_idx !== 2047)
      $display("FAIL t1_synch: got %0d pulses at %0d expected 1 at 2047", synch_hi, synch_idx);
    else n_pass++;
  endtask

  task automatic test_duty_clamp();
    logic [11:0] lv [3];
    logic [11:0] rv [3];
    int e1l [3];
    int e2l [3];
    int e1r [3];
    int e2r [3];
    lv  = '{12'h500, 12'h3FF, 12'h001};
    rv  = '{12'h800, 12'hC01, 12'hFFF};
    e1l = '{2015, 2015, 993};
    e2l = '{0,    0,    991};
    e1r = '{0,    0,    991};
    e2r = '{2048, 2015, 993};
    for (int k = 0; k < 3; k++) begin
      lft_spd = lv[k]; rght_spd = rv[k];
      run_period(2048, 2048);
      run_period(2048, 2048);
      n_chk++;
      if (p1l_hi !== e1l[k]) $display("FAIL clamp%0d_lft_pwm1: got %0d expected %0d", k, p1l_hi, e1l[k]); else n_pass++;
      n_chk++;
      if (p2l_hi !== e2l[k]) $display("FAIL clamp%0d_lft_pwm2: got %0d expected %0d", k, p2l_hi, e2l[k]); else n_pass++;
      n_chk++;
      if (p1r_hi !== e1r[k]) $display("FAIL clamp%0d_rght_pwm1: got %0d expected %0d", k, p1r_hi, e1r[k]); else n_pass++;
      n_chk++;
      if (p2r_hi !== e2r[k]) $display("FAIL clamp%0d_rght_pwm2: got %0d expected %0d", k, p2r_hi, e2r[k]); else n_pass++;
      n_chk++;
      if (overlap !== 0) $display("FAIL clamp%0d_overlap: got %0d expected 0", k, overlap); else n_pass++;
    end
  endtask

  task automatic test_mid_period_update();
    int hi = 0;
    lft_spd = 12'h000; rght_spd = 12'h000;
    run_period(2048, 2048);
    for (int idx = 0; idx < 2048; idx++) begin
      @(negedge clk);
      if (lft_pwm1) hi++;
      if (idx == 500) lft_spd = 12'h200;
    end
    n_chk++;
    if (hi !== 992) $display("FAIL t3_old_period_pwm1: got %0d expected 992", hi); else n_pass++;
    run_period(2048, 2048);
    n_chk++;
    if (p1l_hi !== 1504) $display("FAIL t3_new_period_pwm1: got %0d expected 1504", p1l_hi); else n_pass++;
    n_chk++;
    if (p2l_hi !== 480) $display("FAIL t3_new_period_pwm2: got %0d expected 480", p2l_hi); else n_pass++;
    n_chk++;
    if (p1r_hi !== 992) $display("FAIL t3_rght_unchanged: got %0d expected 992", p1r_hi); else n_pass++;
    lft_spd = 12'h000;
  endtask

`ifdef MTR_OVR_I_SHTDWN_EN
  task automatic test_ovr_shutdown();
    logic sh_acc;
    int   off_hi = 0;
    run_period(200, 2048);
    sh_acc = sh_any;
    for (int k = 0; k < 3; k++) begin
      run_period(0, 2048);
      sh_acc = sh_acc | sh_any;
    end
    n_chk++;
    if (sh_acc !== 1'b0) $display("FAIL t4_early_trip: shtdwn got %b expected 0", sh_acc); else n_pass++;
    run_period(0, 2048);
    n_chk++;
    if (sh_first !== 1'b1) $display("FAIL t4_trip: shtdwn got %b expected 1", sh_first); else n_pass++;
    n_chk++;
    if (late_gates !== 0) $display("FAIL t4_gates_off: got %0d high samples expected 0", late_gates); else n_pass++;
    OVR_I = 1'b0; pwr_up = 1'b0;
    @(negedge clk);
    pwr_up = 1'b1;
    n_chk++;
    if (shtdwn !== 1'b0) $display("FAIL t4_clear: shtdwn got %b expected 0", shtdwn); else n_pass++;
    for (int idx = 1; idx < 2048; idx++) begin
      @(negedge clk);
      if (lft_pwm1 || lft_pwm2 || rght_pwm1 || rght_pwm2) off_hi++;
    end
    n_chk++;
    if (off_hi !== 0) $display("FAIL t4_no_partial: got %0d high samples expected 0", off_hi); else n_pass++;
    run_period(0, 128);
    n_chk++;
    if (p1l_hi !== 992) $display("FAIL t4_resume: lft_pwm1 got %0d expected 992", p1l_hi); else n_pass++;
    sh_acc = sh_any;
    run_period(0, 128);
    sh_acc = sh_acc | sh_any;
    run_period(0, 128);
    sh_acc = sh_acc | sh_any;
    run_period(0, 128);
    sh_acc = sh_acc | sh_any;
    n_chk++;
    if (sh_acc !== 1'b0) $display("FAIL t4_blank: shtdwn got %b expected 0", sh_acc); else n_pass++;
  endtask

  task automatic test_flt_clear();
    logic sh_acc = 1'b0;
    for (int k = 0; k < 7; k++) begin
      if (k == 3) run_period(2048, 2048);
      else        run_period(500, 501);
      sh_acc = sh_acc | sh_any;
    end
    n_chk++;
    if (sh_acc !== 1'b0) $display("FAIL t5_cleared: shtdwn got %b expected 0", sh_acc); else n_pass++;
    run_period(500, 501);
    n_chk++;
    if (sh_any !== 1'b0) $display("FAIL t5_fourth_period: shtdwn got %b expected 0", sh_any); else n_pass++;
    run_period(2048, 2048);
    n_chk++;
    if (sh_first !== 1'b1) $display("FAIL t5_trip_after_4: shtdwn got %b expected 1", sh_first); else n_pass++;
    pwr_up = 1'b0;
    @(negedge clk);
    pwr_up = 1'b1;
    n_chk++;
    if (shtdwn !== 1'b0) $display("FAIL t5_clear: shtdwn got %b expected 0", shtdwn); else n_pass++;
    wait_synch();
  endtask
`else
  task automatic test_ovr_ignored();
    logic sh_acc;
    run_period(200, 2048);
    sh_acc = sh_any;
    for (int k = 0; k < 4; k++) begin
      run_period(0, 2048);
      sh_acc = sh_acc | sh_any;
    end
    OVR_I = 1'b0;
    n_chk++;
    if (sh_acc !== 1'b0) $display("FAIL ovr_ignored_shtdwn: got %b expected 0", sh_acc); else n_pass++;
    n_chk++;
    if (p1l_hi !== 992) $display("FAIL ovr_ignored_lft_pwm1: got %0d expected 992", p1l_hi); else n_pass++;
    n_chk++;
    if (p1r_hi !== 992) $display("FAIL ovr_ignored_rght_pwm1: got %0d expected 992", p1r_hi); else n_pass++;
  endtask
`endif

  task automatic test_reset_mid();
    int hi1 = 0, hi2 = 0, rise = -1, sidx = -1;
    wait_synch();
    repeat (500) @(negedge clk);
    n_chk++;
    if (lft_pwm1 !== 1'b1) $display("FAIL t6_pre_reset: lft_pwm1 got %b expected 1", lft_pwm1); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({lft_pwm1, lft_pwm2, rght_pwm1, rght_pwm2, PWM_synch, shtdwn} !== 6'b0)
      $display("FAIL t6_async_reset: got %b expected 000000",
               {lft_pwm1, lft_pwm2, rght_pwm1, rght_pwm2, PWM_synch, shtdwn});
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int idx = 0; idx < 2048; idx++) begin
      if (idx > 0) @(negedge clk);
      if (lft_pwm1) begin hi1++; if (rise < 0) rise = idx; end
      if (lft_pwm2) hi2++;
      if (PWM_synch && sidx < 0) sidx = idx;
    end
    n_chk++;
    if (rise !== 33) $display("FAIL t6_first_rise: got %0d expected 33", rise); else n_pass++;
    n_chk++;
    if (hi1 !== 992) $display("FAIL t6_pwm1: got %0d expected 992", hi1); else n_pass++;
    n_chk++;
    if (hi2 !== 991) $display("FAIL t6_pwm2: got %0d expected 991", hi2); else n_pass++;
    n_chk++;
    if (sidx !== 2047) $display("FAIL t6_synch: got %0d expected 2047", sidx); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_stopped_50pct();
    test_duty_clamp();
    test_mid_period_update();
`ifdef MTR_OVR_I_SHTDWN_EN
    test_ovr_shutdown();
    test_flt_clear();
`else
    test_ovr_ignored();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
